// File: rtl/lcd_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_seq_ctrl_pkg
//   Shared definitions for the HD44780-class LCD sequencer:
//   - FSM state encodings (legacy-compatible 3-bit constants)
//   - command codes CMD_CLEAR / CMD_HOME and the RS bit index of a memory word
//   - us_to_cycles(): execution-delay-to-clock-cycle conversion
//   - is_long_word(): selects the long execution delay for clear/home
// ---------------------------------------------------------------------------
package lcd_seq_ctrl_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_SETUP = 3'd2;
   localparam logic [2:0] ST_PULSE = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;
   localparam logic [2:0] ST_WAIT  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;
   localparam logic [2:0] ST_PWRUP = 3'd7;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam int         RS_BIT    = 8;

   // ceil(clk_hz * t_us / 1e6), never less than one cycle
   function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                                input longint unsigned t_us);
      longint unsigned c;
      c = (clk_hz * t_us + 64'd999_999) / 64'd1_000_000;
      return (c == 64'd0) ? 32'd1 : 32'(c);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clear (0x01) and home (0x02/0x03) share D[7:2]==0; RS must be 0.
   function automatic logic is_long_word(input logic [8:0] w);
      return !w[RS_BIT] && ((w[7:2] == CMD_CLEAR[7:2]) || (w[7:2] == CMD_HOME[7:2]));
   endfunction

endpackage

// File: rtl/lcd_seq_ctrl_delay_counter.sv
// ---------------------------------------------------------------------------
// lcd_seq_ctrl_delay_counter
//   Loadable down-counter shared by every timed phase of the LCD sequencer
//   (RS/DB setup, E high, execution delay, power-up wait).
//   A phase of L cycles loads L-1; the phase ends on the cycle zero_o is set.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset (count -> RST_VAL)
//   load_i          load load_val_i (takes priority over counting)
//   load_val_i      value to load
//   en_i            count down by one per cycle, saturating at zero
//   zero_o          count is zero
// ---------------------------------------------------------------------------
module lcd_seq_ctrl_delay_counter #(
   parameter int unsigned    W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_seq_ctrl
//   HD44780-class LCD sequencer. On i_start it reads words i_addr_begin ..
//   i_addr_end (inclusive, wrapping modulo 2^WIDTH_MEM) from a sync-read
//   memory and drives RS/DB/E with setup time, E pulse, one hold cycle and
//   a per-word execution delay (long for clear/home, short otherwise).
//   BUS_4BIT=1 sends each word as high then low nibble on o_db[7:4], with a
//   short delay between nibbles.
//   Optional macro LCD_POWERUP_WAIT_EN: after reset the FSM waits 40 ms in
//   PWRUP (o_busy=1, starts ignored) before reaching IDLE.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               start request, sampled only in IDLE
//   i_addr_begin/_end     address range, captured on accepted start
//   o_addr / i_mem_data   memory address; {RS,D[7:0]} valid one cycle later
//   o_rs, o_rw, o_db, o_e LCD pins (o_rw tied 0, o_e registered)
//   o_busy, o_done        sequence status / one-cycle completion pulse
//   o_dbg_state           current FSM state encoding
// Handshake: a start is accepted only when i_start=1 in IDLE; o_busy is 1
//   from the following cycle until the last word's delay expires, then
//   o_done pulses for one cycle (o_busy already 0) and the FSM returns to
//   IDLE. Starts seen while busy or during the o_done cycle are dropped.
// ---------------------------------------------------------------------------
module lcd_seq_ctrl
   import lcd_seq_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 1_000_000,
   parameter int unsigned WIDTH_MEM   = 4,
   parameter bit          BUS_4BIT    = 1'b0,
   parameter int unsigned T_LONG_US   = 1530,
   parameter int unsigned T_SHORT_US  = 37,
   parameter int unsigned E_SETUP_CYC = 1,
   parameter int unsigned E_HIGH_CYC  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [WIDTH_MEM-1:0] i_addr_begin,
   input  logic [WIDTH_MEM-1:0] i_addr_end,
   output logic [WIDTH_MEM-1:0] o_addr,
   input  logic [8:0]           i_mem_data,
   output logic                 o_rs,
   output logic                 o_rw,
   output logic [7:0]           o_db,
   output logic                 o_e,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2:0]           o_dbg_state
);

   localparam int unsigned N_LONG  = us_to_cycles(CLK_HZ, T_LONG_US);
   localparam int unsigned N_SHORT = us_to_cycles(CLK_HZ, T_SHORT_US);
`ifdef LCD_POWERUP_WAIT_EN
   localparam int unsigned N_PWR   = us_to_cycles(CLK_HZ, 40_000);
`else
   localparam int unsigned N_PWR   = 1;
`endif
   localparam int unsigned N_MAX   = max_u(max_u(N_LONG, N_SHORT),
                                           max_u(max_u(E_SETUP_CYC, E_HIGH_CYC), N_PWR));
   localparam int unsigned CNT_W   = $clog2(N_MAX + 1);

`ifdef LCD_POWERUP_WAIT_EN
   localparam logic [2:0]       RST_STATE = ST_PWRUP;
   localparam logic             RST_BUSY  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(N_PWR - 1);
`else
   localparam logic [2:0]       RST_STATE = ST_IDLE;
   localparam logic             RST_BUSY  = 1'b0;
   localparam logic [CNT_W-1:0] CNT_RST   = '0;
`endif

   logic [2:0]           state_q, state_d;
   logic [WIDTH_MEM-1:0] addr_q, addr_d;
   logic [WIDTH_MEM-1:0] end_q, end_d;
   logic [8:0]           word_q, word_d;
   logic                 fresh_q, fresh_d;
   logic                 nibble_q, nibble_d;
   logic                 e_q, busy_q, done_q;
   logic                 cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0]     cnt_val;

   lcd_seq_ctrl_delay_counter #(
      .W       (CNT_W),
      .RST_VAL (CNT_RST)
   ) u_delay (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .en_i       (cnt_en),
      .zero_o     (cnt_zero)
   );

   assign cnt_en = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                   (state_q == ST_WAIT)  || (state_q == ST_PWRUP);

   // Memory data only arrives in the first SETUP cycle after FETCH, so that
   // cycle drives the bus straight from i_mem_data while it is latched.
   assign word_d = fresh_q ? i_mem_data : word_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      end_d    = end_q;
      nibble_d = nibble_q;
      fresh_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_FETCH;
               addr_d  = i_addr_begin;
               end_d   = i_addr_end;
            end
         end
         ST_FETCH: begin
            state_d  = ST_SETUP;
            fresh_d  = 1'b1;
            nibble_d = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(E_SETUP_CYC - 1);
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               state_d  = ST_PULSE;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(E_HIGH_CYC - 1);
            end
         end
         ST_PULSE: begin
            if (cnt_zero) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
            // The word's own delay follows only its final transfer.
            if (is_long_word(word_q) && (!BUS_4BIT || nibble_q)) begin
               cnt_val = CNT_W'(N_LONG - 1);
            end else begin
               cnt_val = CNT_W'(N_SHORT - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               if (BUS_4BIT && !nibble_q) begin
                  state_d  = ST_SETUP;
                  nibble_d = 1'b1;
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(E_SETUP_CYC - 1);
               end else if (addr_q == end_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FETCH;
                  addr_d  = addr_q + WIDTH_MEM'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_PWRUP: begin
`ifdef LCD_POWERUP_WAIT_EN
            if (cnt_zero) state_d = ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= RST_STATE;
         addr_q   <= '0;
         end_q    <= '0;
         word_q   <= '0;
         fresh_q  <= 1'b0;
         nibble_q <= 1'b0;
         e_q      <= 1'b0;
         busy_q   <= RST_BUSY;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         end_q    <= end_d;
         word_q   <= word_d;
         fresh_q  <= fresh_d;
         nibble_q <= nibble_d;
         e_q      <= (state_d == ST_PULSE);
         busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q   <= (state_d == ST_DONE);
      end
   end

   always_comb begin
      if (BUS_4BIT) begin
         o_db = nibble_q ? {word_d[3:0], 4'h0} : {word_d[7:4], 4'h0};
      end else begin
         o_db = word_d[7:0];
      end
   end

   assign o_rs        = word_d[RS_BIT];
   assign o_rw        = 1'b0;
   assign o_e         = e_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_addr      = addr_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_seq_ctrl
//   Two sequencer instances (8-bit bus and 4-bit bus) at CLK_HZ=1 MHz, so the
//   long delay is 1530 cycles and the short delay 37 cycles. A transfer-level
//   model expands each accepted start into per-cycle expectations; literal
//   E-pulse timings/values pin the model for each directed case.
// ---------------------------------------------------------------------------
module tb_lcd_seq_ctrl;

   localparam int M_LONG  = 1530;
   localparam int M_SHORT = 37;
   localparam int M_SETUP = 1;
   localparam int M_HIGH  = 1;

   typedef struct packed {
      logic       e;
      logic       busy;
      logic       done;
      logic       chk_bus;
      logic       rs;
      logic [7:0] db;
      logic       chk_addr;
      logic [3:0] addr;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DUT signals ----------------
   logic       start8, start4;
   logic [3:0] beg8, end8, beg4, end4;
   logic [3:0] addr8, addr4;
   logic [8:0] rd8, rd4;
   logic       rs8, rw8, e8, busy8, done8;
   logic       rs4, rw4, e4, busy4, done4;
   logic [7:0] db8, db4;
   logic [2:0] st8, st4;
   logic [8:0] mem8 [16];
   logic [8:0] mem4 [16];

   always @(posedge clk) rd8 <= mem8[addr8];
   always @(posedge clk) rd4 <= mem4[addr4];

   lcd_seq_ctrl #(.CLK_HZ(1_000_000), .WIDTH_MEM(4), .BUS_4BIT(1'b0)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start8),
      .i_addr_begin(beg8), .i_addr_end(end8), .o_addr(addr8), .i_mem_data(rd8),
      .o_rs(rs8), .o_rw(rw8), .o_db(db8), .o_e(e8),
      .o_busy(busy8), .o_done(done8), .o_dbg_state(st8)
   );

   lcd_seq_ctrl #(.CLK_HZ(1_000_000), .WIDTH_MEM(4), .BUS_4BIT(1'b1)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4),
      .i_addr_begin(beg4), .i_addr_end(end4), .o_addr(addr4), .i_mem_data(rd4),
      .o_rs(rs4), .o_rw(rw4), .o_db(db4), .o_e(e4),
      .o_busy(busy4), .o_done(done4), .o_dbg_state(st4)
   );

   // ---------------- scoreboard ----------------
   exp_t exp8_q[$];
   exp_t exp4_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(input bit sel);
      return sel ? exp4_q.size() : exp8_q.size();
   endfunction

   task automatic push_exp(input bit sel, input exp_t r);
      if (sel) exp4_q.push_back(r);
      else     exp8_q.push_back(r);
   endtask

   // Transfer-level model: per word one address cycle, then for each bus
   // transfer setup / E-high / hold / delay, then a single done cycle.
   task automatic model_push(input bit sel, input logic [3:0] first, input logic [3:0] last);
      logic [3:0] a;
      logic [8:0] w;
      exp_t       r;
      int         n_xfer;
      int         len;
      bit         is_long;
      a = first;
      n_xfer = sel ? 2 : 1;
      for (int k = 0; k < 16; k++) begin
         w = sel ? mem4[a] : mem8[a];
         is_long = (w[8] == 1'b0) && (w[7:0] <= 8'h03);
         r = '0; r.busy = 1'b1; r.chk_addr = 1'b1; r.addr = a;
         push_exp(sel, r);
         for (int n = 0; n < n_xfer; n++) begin
            r = '0; r.busy = 1'b1; r.chk_bus = 1'b1; r.rs = w[8];
            if (!sel)        r.db = w[7:0];
            else if (n == 0) r.db = {w[7:4], 4'h0};
            else             r.db = {w[3:0], 4'h0};
            repeat (M_SETUP) push_exp(sel, r);
            r.e = 1'b1;
            repeat (M_HIGH) push_exp(sel, r);
            r.e = 1'b0;
            push_exp(sel, r);
            len = ((n == n_xfer - 1) && is_long) ? M_LONG : M_SHORT;
            r = '0; r.busy = 1'b1;
            repeat (len) push_exp(sel, r);
         end
         if (a == last) break;
         a = a + 4'd1;
      end
      r = '0; r.done = 1'b1;
      push_exp(sel, r);
   endtask

   task automatic cmp(input bit sel);
      exp_t       r;
      string      t;
      logic       a_e, a_busy, a_done, a_rs, a_rw;
      logic [7:0] a_db;
      logic [3:0] a_addr;
      r = '0;
      if (sel) begin
         t = "dut4";
         if (exp4_q.size() > 0) r = exp4_q.pop_front();
         a_e = e4; a_busy = busy4; a_done = done4; a_rs = rs4; a_rw = rw4; a_db = db4; a_addr = addr4;
      end else begin
         t = "dut8";
         if (exp8_q.size() > 0) r = exp8_q.pop_front();
         a_e = e8; a_busy = busy8; a_done = done8; a_rs = rs8; a_rw = rw8; a_db = db8; a_addr = addr8;
      end
      chk({t, ".o_e"},    32'(a_e),    32'(r.e));
      chk({t, ".o_busy"}, 32'(a_busy), 32'(r.busy));
      chk({t, ".o_done"}, 32'(a_done), 32'(r.done));
      chk({t, ".o_rw"},   32'(a_rw),   32'(0));
      if (r.chk_bus) begin
         chk({t, ".o_rs"}, 32'(a_rs), 32'(r.rs));
         chk({t, ".o_db"}, 32'(a_db), 32'(r.db));
      end
      if (r.chk_addr) chk({t, ".o_addr"}, 32'(a_addr), 32'(r.addr));
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
         cmp(1'b0);
         cmp(1'b1);
      end
   end

   // ---------------- E-pulse monitor ----------------
   int         cyc = 0;
   int         rise8_t[$];
   int         rise4_t[$];
   logic [8:0] rise8_v[$];
   logic [8:0] rise4_v[$];
   logic [3:0] rise8_a[$];
   int         done8_n = 0;
   int         done4_n = 0;
   logic       e8_prev = 1'b0;
   logic       e4_prev = 1'b0;

   initial forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (e8 === 1'b1 && e8_prev !== 1'b1) begin
         rise8_t.push_back(cyc); rise8_v.push_back({rs8, db8}); rise8_a.push_back(addr8);
      end
      if (e4 === 1'b1 && e4_prev !== 1'b1) begin
         rise4_t.push_back(cyc); rise4_v.push_back({rs4, db4});
      end
      e8_prev = e8;
      e4_prev = e4;
      if (done8 === 1'b1) done8_n++;
      if (done4 === 1'b1) done4_n++;
   end

   task automatic clear_logs();
      rise8_t.delete(); rise8_v.delete(); rise8_a.delete();
      rise4_t.delete(); rise4_v.delete();
      done8_n = 0; done4_n = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic go(input bit sel, input logic [3:0] b, input logic [3:0] e, input bit accept);
      @(negedge clk);
      if (sel) begin beg4 = b; end4 = e; start4 = 1'b1; end
      else     begin beg8 = b; end8 = e; start8 = 1'b1; end
      if (accept) model_push(sel, b, e);
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic wait_idle(input bit sel, input string name);
      int k;
      k = 0;
      while (qsize(sel) != 0 && k < 6000) begin
         @(negedge clk);
         k++;
      end
      n_chk++;
      if (qsize(sel) != 0) begin
         n_fail++;
         $display("FAIL %s timeout: %0d expected cycles left, required 0", name, qsize(sel));
         if (sel) exp4_q.delete(); else exp8_q.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int k;
      rst_n = 1'b0;
      start8 = 1'b0; start4 = 1'b0;
      beg8 = '0; end8 = '0; beg4 = '0; end4 = '0;
      for (int i = 0; i < 16; i++) begin mem8[i] = '0; mem4[i] = '0; end

      repeat (2) @(negedge clk);
      chk("reset.o_e",    32'(e8),    32'(0));
      chk("reset.o_busy", 32'(busy8), 32'(0));
      chk("reset.o_done", 32'(done8), 32'(0));
      chk("reset.o_addr", 32'(addr8), 32'(0));
      chk("reset.o_rs",   32'(rs8),   32'(0));
      chk("reset.o_db",   32'(db8),   32'(0));
      chk("reset4.o_db",  32'(db4),   32'(0));
      chk("reset4.o_busy",32'(busy4), 32'(0));
      rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);

      // T1: three short words; a start pulse mid-sequence must be ignored
      mem8[0] = 9'h038; mem8[1] = 9'h00C; mem8[2] = 9'h141;
      clear_logs();
      go(1'b0, 4'd0, 4'd2, 1'b1);
      repeat (60) @(negedge clk);
      go(1'b0, 4'd9, 4'd9, 1'b0);
      wait_idle(1'b0, "t1");
      chk("t1.pulses", 32'(rise8_t.size()), 32'(3));
      chk("t1.done_n", 32'(done8_n), 32'(1));
      if (rise8_t.size() == 3) begin
         chk("t1.word0", 32'(rise8_v[0]), 32'h038);
         chk("t1.word1", 32'(rise8_v[1]), 32'h00C);
         chk("t1.word2", 32'(rise8_v[2]), 32'h141);
         chk("t1.gap01", 32'(rise8_t[1] - rise8_t[0]), 32'(41));
         chk("t1.gap12", 32'(rise8_t[2] - rise8_t[1]), 32'(41));
      end

      // T2: clear and home(0x03) are long, 0x004 is short
      mem8[0] = 9'h001; mem8[1] = 9'h003; mem8[2] = 9'h004; mem8[3] = 9'h038;
      clear_logs();
      go(1'b0, 4'd0, 4'd3, 1'b1);
      wait_idle(1'b0, "t2");
      chk("t2.pulses", 32'(rise8_t.size()), 32'(4));
      if (rise8_t.size() == 4) begin
         chk("t2.gap_clear", 32'(rise8_t[1] - rise8_t[0]), 32'(1534));
         chk("t2.gap_home",  32'(rise8_t[2] - rise8_t[1]), 32'(1534));
         chk("t2.gap_short", 32'(rise8_t[3] - rise8_t[2]), 32'(41));
      end

      // T3: 4-bit bus, single word 0x128 at begin=end=5
      mem4[5] = 9'h128;
      clear_logs();
      go(1'b1, 4'd5, 4'd5, 1'b1);
      wait_idle(1'b1, "t3");
      chk("t3.pulses", 32'(rise4_t.size()), 32'(2));
      chk("t3.done_n", 32'(done4_n), 32'(1));
      if (rise4_t.size() == 2) begin
         chk("t3.hi",  32'(rise4_v[0]), 32'h120);
         chk("t3.lo",  32'(rise4_v[1]), 32'h180);
         chk("t3.gap", 32'(rise4_t[1] - rise4_t[0]), 32'(40));
      end

      // T3b: 4-bit clear then data; long delay only after the low nibble
      mem4[6] = 9'h001; mem4[7] = 9'h141;
      clear_logs();
      go(1'b1, 4'd6, 4'd7, 1'b1);
      wait_idle(1'b1, "t3b");
      chk("t3b.pulses", 32'(rise4_t.size()), 32'(4));
      if (rise4_t.size() == 4) begin
         chk("t3b.v1",   32'(rise4_v[1]), 32'h010);
         chk("t3b.v2",   32'(rise4_v[2]), 32'h140);
         chk("t3b.gap0", 32'(rise4_t[1] - rise4_t[0]), 32'(40));
         chk("t3b.gap1", 32'(rise4_t[2] - rise4_t[1]), 32'(1534));
         chk("t3b.gap2", 32'(rise4_t[3] - rise4_t[2]), 32'(40));
      end

      // T4: wrapping range 14 -> 1
      mem8[14] = 9'h141; mem8[15] = 9'h142; mem8[0] = 9'h143; mem8[1] = 9'h144;
      clear_logs();
      go(1'b0, 4'd14, 4'd1, 1'b1);
      wait_idle(1'b0, "t4");
      chk("t4.pulses", 32'(rise8_t.size()), 32'(4));
      if (rise8_t.size() == 4) begin
         chk("t4.addr0", 32'(rise8_a[0]), 32'(14));
         chk("t4.addr1", 32'(rise8_a[1]), 32'(15));
         chk("t4.addr2", 32'(rise8_a[2]), 32'(0));
         chk("t4.addr3", 32'(rise8_a[3]), 32'(1));
         chk("t4.word2", 32'(rise8_v[2]), 32'h143);
      end

      // T5: begin==end single word; a start held during the done cycle is dropped
      mem8[5] = 9'h155;
      clear_logs();
      go(1'b0, 4'd5, 4'd5, 1'b1);
      k = 0;
      while (done8 !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t5.done_seen", 32'(done8), 32'(1));
      beg8 = 4'd5; end8 = 4'd5; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_idle(1'b0, "t5");
      repeat (50) @(negedge clk);
      chk("t5.pulses", 32'(rise8_t.size()), 32'(1));
      chk("t5.done_n", 32'(done8_n), 32'(1));

      // T6: reset during the E pulse clears outputs at once
      mem8[0] = 9'h038; mem8[1] = 9'h00C; mem8[2] = 9'h141;
      go(1'b0, 4'd0, 4'd2, 1'b1);
      k = 0;
      while (e8 !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t6.e_seen", 32'(e8), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("t6.o_e",    32'(e8),    32'(0));
      chk("t6.o_busy", 32'(busy8), 32'(0));
      chk("t6.o_done", 32'(done8), 32'(0));
      chk("t6.o_addr", 32'(addr8), 32'(0));
      chk("t6.o_db",   32'(db8),   32'(0));
      exp8_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_logs();
      go(1'b0, 4'd5, 4'd5, 1'b1);
      wait_idle(1'b0, "t6");
      chk("t6.pulses", 32'(rise8_t.size()), 32'(1));
      chk("t6.done_n", 32'(done8_n), 32'(1));

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
